// File: rtl/verifier_sumcheck_pkg.sv
// Shared types for the sumcheck round verifier and its sequencer.
//   NBITS, FQ : field width and prime taken from field_arith_defs
//   NC        : number of round coefficients (3, or 4 when VERIFIER_SUMCHECK_CUBIC_EN)
//   state_t   : round FSM states
//   fadd      : modular add of two canonical residues
`include "field_arith_defs.sv"

package verifier_sumcheck_pkg;

    localparam int unsigned NBITS = `F_NBITS;
    localparam logic [NBITS-1:0] FQ = `F_Q;

`ifdef VERIFIER_SUMCHECK_CUBIC_EN
    localparam int unsigned NC = 4;
`else
    localparam int unsigned NC = 3;
`endif
    // Highest-degree coefficient index; Horner starts from it.
    localparam int unsigned TOP   = NC - 1;
    localparam int unsigned IDX_W = 2;

    typedef logic [NBITS-1:0] felem_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
`ifdef VERIFIER_SUMCHECK_CUBIC_EN
        ST_SUM3,
`endif
        ST_SUM,
        ST_HMUL,
        ST_HADD,
        ST_DONE
    } state_t;

    function automatic felem_t fadd(felem_t x, felem_t y);
        logic [NBITS:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, FQ}) begin
            s = s - {1'b0, FQ};
        end
        return s[NBITS-1:0];
    endfunction

endpackage

// File: rtl/verifier_sumcheck_round_if.sv
// Round request/result bundle between the verifier round sequencer (master)
// and verifier_sumcheck_round (slave).
//   en, c_in, claim_in, r_in       : request (master -> slave)
//   claim_out, ok, ready, ready_pulse : result/status (slave -> master)
interface verifier_sumcheck_round_if;
    import verifier_sumcheck_pkg::*;

    logic                en;
    felem_t [NC-1:0]     c_in;
    felem_t              claim_in;
    felem_t              r_in;
    felem_t              claim_out;
    logic                ok;
    logic                ready;
    logic                ready_pulse;

    modport master (
        output en, c_in, claim_in, r_in,
        input  claim_out, ok, ready, ready_pulse
    );

    modport slave (
        input  en, c_in, claim_in, r_in,
        output claim_out, ok, ready, ready_pulse
    );

endinterface

// File: rtl/field_adder.sv
// Modular adder: c <= (a + b) mod F_Q on the clock edge where en is high.
//   clk, rstb : clock, asynchronous active-low reset
//   en        : one-cycle operation pulse
//   a, b      : canonical operands
//   c         : registered result, valid the cycle after en
//   ready     : always 1 (single-cycle unit)
module field_adder
    import verifier_sumcheck_pkg::*;
(
    input  logic   clk,
    input  logic   rstb,
    input  logic   en,
    input  felem_t a,
    input  felem_t b,
    output felem_t c,
    output logic   ready
);

    felem_t c_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            c_q <= '0;
        end else if (en) begin
            c_q <= fadd(a, b);
        end
    end

    assign c     = c_q;
    assign ready = 1'b1;

endmodule

// File: rtl/field_arith_defs.sv
// Field arithmetic constants shared by the sumcheck verifier slice.
//   F_NBITS   : width of a canonical field element
//   F_Q       : field prime (Mersenne 2^61 - 1)
//   F_Q_P1_MI : 2^F_NBITS - F_Q, the additive complement of the prime
// Definitions only; include-guarded so repeated inclusion is harmless.
`ifndef FIELD_ARITH_DEFS_SV
`define FIELD_ARITH_DEFS_SV
`define F_NBITS 61
`define F_Q 61'h1fff_ffff_ffff_ffff
`define F_Q_P1_MI 61'd1
`endif

// File: rtl/field_multiplier.sv
// Bit-serial modular multiplier: c = a * b mod F_Q, MSB-first double-and-add,
// one bit of b per cycle.
//   clk, rstb : clock, asynchronous active-low reset
//   en        : one-cycle start pulse, accepted only when ready
//   a, b      : canonical operands, captured on start
//   c         : result, valid once ready returns high
//   ready     : low while an operation is in progress
module field_multiplier
    import verifier_sumcheck_pkg::*;
(
    input  logic   clk,
    input  logic   rstb,
    input  logic   en,
    input  felem_t a,
    input  felem_t b,
    output felem_t c,
    output logic   ready
);

    localparam int unsigned CW = $clog2(NBITS + 1);

    felem_t          a_q, b_q, acc_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    felem_t          acc_dbl, acc_step;

    always_comb begin
        acc_dbl  = fadd(acc_q, acc_q);
        acc_step = b_q[NBITS-1] ? fadd(acc_dbl, a_q) : acc_dbl;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (busy_q) begin
            acc_q <= acc_step;
            b_q   <= {b_q[NBITS-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
            end
        end else if (en) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            cnt_q  <= CW'(NBITS);
            busy_q <= 1'b1;
        end
    end

    assign c     = acc_q;
    assign ready = ~busy_q;

endmodule

// File: rtl/verifier_sumcheck_round.sv
// Verifier side of one sumcheck round: checks 2*c0 + c1 + c2 [+ c3] == claim_in
// and evaluates f(r_in) by Horner to produce the next claim.
//   clk, rstb : clock, asynchronous active-low reset
//   bus       : verifier_sumcheck_round_if.slave (en, c_in, claim_in, r_in in;
//               claim_out, ok, ready, ready_pulse out)
// Build option: define VERIFIER_SUMCHECK_CUBIC_EN for cubic rounds (four coefficients).
module verifier_sumcheck_round
    import verifier_sumcheck_pkg::*;
(
    input  logic                      clk,
    input  logic                      rstb,
    verifier_sumcheck_round_if.slave  bus
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ok_next_q, ok_next_d;
    logic               en_dly_q, ready_dly_q;
    felem_t [NC-1:0]    c_q;
    felem_t             claim_q, r_q, claim_out_q;
    logic               ok_q;
    logic               start, ready, capture, out_ld;

    logic   add0_en_q, add0_go, add0_rdy, add1_en_q, add1_go, add1_rdy;
    logic   mul_en_q, mul_go, mul_rdy;
    felem_t add0_a_q, add0_b_q, add0_a_d, add0_b_d, add0_c;
    felem_t add1_a_q, add1_b_q, add1_a_d, add1_b_d, add1_c;
    felem_t mul_a_q, mul_b_q, mul_a_d, mul_b_d, mul_c;
    logic   add0_done, add1_done, mul_done;

    // en_dly resets high so an en held through reset does not count as an edge.
    assign start     = bus.en & ~en_dly_q;
    assign ready     = (state_q == ST_IDLE) & ~start;
    // A unit's result is usable once it is ready and its launch pulse has drained.
    assign add0_done = add0_rdy & ~add0_en_q;
    assign add1_done = add1_rdy & ~add1_en_q;
    assign mul_done  = mul_rdy & ~mul_en_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ok_next_d = ok_next_q;
        capture   = 1'b0;
        out_ld    = 1'b0;
        add0_go   = 1'b0;
        add0_a_d  = add0_a_q;
        add0_b_d  = add0_b_q;
        add1_go   = 1'b0;
        add1_a_d  = add1_a_q;
        add1_b_d  = add1_b_q;
        mul_go    = 1'b0;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture  = 1'b1;
                    add0_go  = 1'b1;
                    add0_a_d = bus.c_in[0];
                    add0_b_d = bus.c_in[1];
                    add1_go  = 1'b1;
                    add1_a_d = bus.c_in[0];
                    add1_b_d = bus.c_in[2];
                    mul_go   = 1'b1;
                    mul_a_d  = bus.c_in[TOP];
                    mul_b_d  = bus.r_in;
                    idx_d    = IDX_W'(TOP - 1);
                    state_d  = ST_PRE;
                end
            end
            ST_PRE: begin
                if (add0_done && add1_done && mul_done) begin
                    add0_go  = 1'b1;
                    add0_a_d = add0_c;
                    add0_b_d = add1_c;
                    add1_go  = 1'b1;
                    add1_a_d = mul_c;
                    add1_b_d = c_q[idx_q];
`ifdef VERIFIER_SUMCHECK_CUBIC_EN
                    state_d  = ST_SUM3;
`else
                    state_d  = ST_SUM;
`endif
                end
            end
`ifdef VERIFIER_SUMCHECK_CUBIC_EN
            ST_SUM3: begin
                if (add0_done) begin
                    add0_go  = 1'b1;
                    add0_a_d = add0_c;
                    add0_b_d = c_q[3];
                    state_d  = ST_SUM;
                end
            end
`endif
            ST_SUM: begin
                if (add0_done && add1_done) begin
                    ok_next_d = (add0_c == claim_q);
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        mul_go  = 1'b1;
                        mul_a_d = add1_c;
                        mul_b_d = r_q;
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_HMUL;
                    end
                end
            end
            ST_HMUL: begin
                if (mul_done) begin
                    add1_go  = 1'b1;
                    add1_a_d = mul_c;
                    add1_b_d = c_q[idx_q];
                    state_d  = ST_HADD;
                end
            end
            ST_HADD: begin
                if (add1_done) begin
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        mul_go  = 1'b1;
                        mul_a_d = add1_c;
                        mul_b_d = r_q;
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_HMUL;
                    end
                end
            end
            ST_DONE: begin
                out_ld  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            ok_next_q   <= 1'b0;
            en_dly_q    <= 1'b1;
            ready_dly_q <= 1'b1;
            c_q         <= '0;
            claim_q     <= '0;
            r_q         <= '0;
            claim_out_q <= '0;
            ok_q        <= 1'b0;
            add0_en_q   <= 1'b0;
            add0_a_q    <= '0;
            add0_b_q    <= '0;
            add1_en_q   <= 1'b0;
            add1_a_q    <= '0;
            add1_b_q    <= '0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ok_next_q   <= ok_next_d;
            en_dly_q    <= bus.en;
            ready_dly_q <= ready;
            add0_en_q   <= add0_go;
            add0_a_q    <= add0_a_d;
            add0_b_q    <= add0_b_d;
            add1_en_q   <= add1_go;
            add1_a_q    <= add1_a_d;
            add1_b_q    <= add1_b_d;
            mul_en_q    <= mul_go;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            if (capture) begin
                c_q     <= bus.c_in;
                claim_q <= bus.claim_in;
                r_q     <= bus.r_in;
            end
            if (out_ld) begin
                claim_out_q <= add1_c;
                ok_q        <= ok_next_q;
            end
        end
    end

    field_adder u_add0 (
        .clk   (clk),
        .rstb  (rstb),
        .en    (add0_en_q),
        .a     (add0_a_q),
        .b     (add0_b_q),
        .c     (add0_c),
        .ready (add0_rdy)
    );

    field_adder u_add1 (
        .clk   (clk),
        .rstb  (rstb),
        .en    (add1_en_q),
        .a     (add1_a_q),
        .b     (add1_b_q),
        .c     (add1_c),
        .ready (add1_rdy)
    );

    field_multiplier u_mul (
        .clk   (clk),
        .rstb  (rstb),
        .en    (mul_en_q),
        .a     (mul_a_q),
        .b     (mul_b_q),
        .c     (mul_c),
        .ready (mul_rdy)
    );

    assign bus.claim_out   = claim_out_q;
    assign bus.ok          = ok_q;
    assign bus.ready       = ready;
    assign bus.ready_pulse = ready & ~ready_dly_q;

endmodule

// File: tb/tb_verifier_sumcheck_round.sv
// Self-checking bench for verifier_sumcheck_round: directed rounds with literal
// results, reset/en-edge corner cases, then randomized rounds against a
// plain-arithmetic polynomial model.
module tb_verifier_sumcheck_round;
    import verifier_sumcheck_pkg::*;

    typedef logic [NC-1:0][NBITS-1:0] cvec_t;
    typedef struct packed {
        logic   ok;
        felem_t claim;
    } res_t;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    verifier_sumcheck_round_if bus ();

    verifier_sumcheck_round dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   rounds = 0;
    res_t pending[$];
    res_t expd = '0;

    function automatic felem_t m_add(felem_t a, felem_t b);
        logic [127:0] s;
        s = (128'(a) + 128'(b)) % 128'(FQ);
        return s[NBITS-1:0];
    endfunction

    function automatic felem_t m_mul(felem_t a, felem_t b);
        logic [127:0] p;
        p = (128'(a) * 128'(b)) % 128'(FQ);
        return p[NBITS-1:0];
    endfunction

    // f(0) + f(1) = 2*c0 + c1 + ... + c_top
    function automatic felem_t m_sum(cvec_t c);
        felem_t s;
        s = m_add(c[0], c[0]);
        for (int i = 1; i < NC; i++) s = m_add(s, c[i]);
        return s;
    endfunction

    // f(r) as a sum of c_i * r^i
    function automatic res_t model(cvec_t c, felem_t claim, felem_t r);
        res_t   res;
        felem_t acc, pw;
        acc = '0;
        pw  = 1;
        for (int i = 0; i < NC; i++) begin
            acc = m_add(acc, m_mul(c[i], pw));
            pw  = m_mul(pw, r);
        end
        res.claim = acc;
        res.ok    = (m_sum(c) == claim);
        return res;
    endfunction

    function automatic felem_t rnd_fe();
        logic [63:0] v;
        felem_t      x;
        v = {$urandom, $urandom};
        x = v[NBITS-1:0];
        case ($urandom_range(7))
            0: x = '0;
            1: x = FQ - 1;
            2: x = 1;
            default: ;
        endcase
        if (x == FQ) x = '0;
        return x;
    endfunction

    // Output checker: outputs must always hold the result of the last finished round.
    always @(negedge clk) begin
        if (!rstb) begin
            expd = '0;
            pending.delete();
        end else if (bus.ready_pulse) begin
            pulses++;
            if (pending.size() == 0) begin
                errors++;
                $display("FAIL spurious_round t=%0t ready_pulse with no round started", $time);
            end else begin
                expd = pending.pop_front();
            end
        end
        checks++;
        if (bus.claim_out !== expd.claim || bus.ok !== expd.ok) begin
            errors++;
            $display("FAIL outputs t=%0t claim_out=%h ok=%b expected claim_out=%h ok=%b",
                     $time, bus.claim_out, bus.ok, expd.claim, expd.ok);
        end
    end

    task automatic check_lit(input string name, input felem_t claim, input logic okv);
        checks++;
        if (bus.claim_out !== claim || bus.ok !== okv) begin
            errors++;
            $display("FAIL %s claim_out=%0d ok=%b expected claim_out=%0d ok=%b",
                     name, bus.claim_out, bus.ok, claim, okv);
        end
    endtask

    task automatic start_round(input cvec_t c, input felem_t claim, input felem_t r);
        @(posedge clk);
        #1;
        bus.c_in     = c;
        bus.claim_in = claim;
        bus.r_in     = r;
        bus.en       = 1'b1;
        pending.push_back(model(c, claim, r));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_round(input int p0);
        int n;
        n = 0;
        while (pulses == p0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (pulses == p0) begin
            errors++;
            $display("FAIL round_timeout no ready_pulse within %0d cycles", n);
            pending.delete();
        end
    endtask

    // poke: scramble inputs and re-pulse en while the round is in flight.
    task automatic run_round(input cvec_t c, input felem_t claim, input felem_t r,
                             input bit poke);
        int p0;
        p0     = pulses;
        bus.en = 1'b0;
        repeat (1 + $urandom_range(2)) @(posedge clk);
        start_round(c, claim, r);
        rounds++;
        if (poke) begin
            bus.claim_in = ~claim;
            bus.r_in     = rnd_fe();
            for (int i = 0; i < NC; i++) bus.c_in[i] = rnd_fe();
            bus.en = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus.en = 1'b1;
            repeat (3) @(posedge clk);
            #1 bus.en = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.en = 1'b0;
        end
        wait_round(p0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cvec_t  c1, c;
        felem_t claim;

        bus.en       = 1'b1;
        bus.c_in     = '0;
        bus.claim_in = '0;
        bus.r_in     = '0;

        // en high through reset release must not start a round.
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_lit("reset_state", 0, 1'b0);
        checks++;
        if (bus.ready !== 1'b1 || pulses != 0) begin
            errors++;
            $display("FAIL en_held_reset ready=%b pulses=%0d expected ready=1 pulses=0",
                     bus.ready, pulses);
        end

        c1    = '0;
        c1[0] = 3;
        c1[1] = 4;
        c1[2] = 5;
        run_round(c1, 15, 2, 1'b0);
        check_lit("t1_quadratic_ok", 31, 1'b1);
        run_round(c1, 16, 2, 1'b0);
        check_lit("t2_quadratic_bad_claim", 31, 1'b0);

        c    = '0;
        c[1] = 1;
        c[2] = FQ - 1;
        run_round(c, 0, 3, 1'b0);
        check_lit("t3_wrap", FQ - 6, 1'b1);

`ifdef VERIFIER_SUMCHECK_CUBIC_EN
        c    = '0;
        c[0] = 1;
        c[1] = 2;
        c[2] = 3;
        c[3] = 4;
        run_round(c, 11, 3, 1'b0);
        check_lit("t4_cubic", 142, 1'b1);
`endif

        // en re-pulse and input changes after start must be ignored.
        run_round(c1, 15, 2, 1'b1);
        check_lit("t5_poke", 31, 1'b1);

        // Reset in the middle of the Horner multiply.
        run_round(c1, 16, 2, 1'b0);
        bus.en = 1'b0;
        @(posedge clk);
        start_round(c1, 15, 2);
        #1 bus.en = 1'b0;
        repeat (100) @(posedge clk);
        #1 rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;
        @(negedge clk);
        check_lit("t6_after_reset", 0, 1'b0);
        checks++;
        if (bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL t6_ready ready=%b expected 1", bus.ready);
        end
        run_round(c1, 15, 2, 1'b0);
        check_lit("t6_next_round", 31, 1'b1);

        for (int n = 0; n < 100; n++) begin
            for (int i = 0; i < NC; i++) c[i] = rnd_fe();
            claim = ($urandom_range(1) == 0) ? m_sum(c) : rnd_fe();
            run_round(c, claim, rnd_fe(), $urandom_range(3) == 0);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (pulses != rounds) begin
            errors++;
            $display("FAIL pulse_count ready_pulses=%0d expected %0d", pulses, rounds);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
